// File: rtl/led_shift_out_if.sv
// Bus between a word producer and led_shift_out: write port, status and the three 595 drive lines.
// wr is taken only in a cycle where busy is low; a wr seen while busy is high is discarded and flagged on drop.
interface led_shift_out_if #(
  parameter int WIDTH = 12
);
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             drop;
  logic             sclk;
  logic             sdout;
  logic             rclk;
  logic [1:0]       state;

  modport master (
    output wr, wdata,
    input  busy, drop, sclk, sdout, rclk, state
  );

  modport slave (
    input  wr, wdata,
    output busy, drop, sclk, sdout, rclk, state
  );
endinterface

// File: rtl/led_shift_out.sv
// Shifts a WIDTH-bit word MSB first into a 74HC595 chain with a divided shift clock,
// then pulses the storage latch for one shift-clock phase.
module led_shift_out #(
  parameter int WIDTH = 12,
  parameter int DIV   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  led_shift_out_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bits_left;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             tick;

  assign tick       = (cnt == CW'(DIV - 1));
  assign shreg_next = shreg << 1;
  assign bus.state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
      bus.busy  <= 1'b0;
      bus.drop  <= 1'b0;
      bus.sclk  <= 1'b0;
      bus.sdout <= 1'b0;
      bus.rclk  <= 1'b0;
    end else begin
      // busy is still high on the edge where it falls, so that wr is dropped too
      bus.drop <= bus.wr && bus.busy;
      case (state)
        IDLE: begin
          if (bus.wr) begin
            shreg     <= bus.wdata;
            bits_left <= BW'(WIDTH);
            bus.busy  <= 1'b1;
            bus.sclk  <= 1'b0;
            bus.sdout <= bus.wdata[WIDTH-1];
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (!bus.sclk) begin
              bus.sclk <= 1'b1;
            end else begin
              // data only moves on the falling edge, a full phase away from the rise
              bus.sclk  <= 1'b0;
              bits_left <= bits_left - 1'b1;
              shreg     <= shreg_next;
              if (bits_left > BW'(1)) begin
                bus.sdout <= shreg_next[WIDTH-1];
              end else begin
                bus.sdout <= 1'b0;
                bus.rclk  <= 1'b1;
                state     <= LATCH;
              end
            end
          end
        end
        LATCH: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            bus.rclk <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_shift_out.sv
// Randomized bench for led_shift_out: three instances (12/4, 1/1, 32/256) checked cycle by cycle
// against a timeline model and frame by frame against a queue of accepted words.
module tb_led_shift_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_shift_out_if #(.WIDTH(12)) bus_m ();
  led_shift_out_if #(.WIDTH(1))  bus_1 ();
  led_shift_out_if #(.WIDTH(32)) bus_32 ();

  led_shift_out #(.WIDTH(12), .DIV(4))   u_dut_m  (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  led_shift_out #(.WIDTH(1),  .DIV(1))   u_dut_1  (.clk(clk), .rst_n(rst_n), .bus(bus_1));
  led_shift_out #(.WIDTH(32), .DIV(256)) u_dut_32 (.clk(clk), .rst_n(rst_n), .bus(bus_32));

  // reference model: acceptance edge and word per instance
  int          k_m = 0, k_1 = 0, k_32 = 0, free_m = 0;
  bit          act_m = 0, act_1 = 0, act_32 = 0;
  logic [31:0] word_m = '0, word_1 = '0, word_32 = '0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q32[$];
  bit          drop_exp[int];

  logic [31:0] bits[3];
  int          nb[3];
  logic        ps[3];
  logic        pr[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // {busy, sclk, sdout, rclk} after edge c, from the frame timeline alone
  function automatic logic [3:0] model_out(input int w, input int dv, input bit act,
                                           input int k, input logic [31:0] word, input int c);
    int d;
    logic [3:0] r;
    r = '0;
    if (act && c >= k) begin
      d = c - k;
      if (d < 2 * w * dv)
        r = {1'b1, 1'((d / dv) % 2), word[w - 1 - d / (2 * dv)], 1'b0};
      else if (d < (2 * w + 1) * dv)
        r = 4'b1001;
    end
    return r;
  endfunction

  task automatic frame_mon(input int i, input logic s, input logic d, input logic r, input int w);
    logic [31:0] e;
    bit has;
    e = '0;
    has = 0;
    if (s && !ps[i]) begin
      bits[i] = {bits[i][30:0], d};
      nb[i]++;
    end
    if (r && !pr[i]) begin
      case (i)
        0: if (exp_q.size() > 0) begin e = exp_q.pop_front(); has = 1; end
        1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); has = 1; end
        default: if (exp_q32.size() > 0) begin e = exp_q32.pop_front(); has = 1; end
      endcase
      if (!has) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_unexpected dut%0d at cycle %0d: got latch pulse expected none", i, cyc);
      end else begin
        chk($sformatf("frame_word_dut%0d", i), bits[i], e);
        chk($sformatf("frame_nbits_dut%0d", i), 32'(nb[i]), 32'(w));
      end
      bits[i] = '0;
      nb[i] = 0;
    end
    ps[i] = s;
    pr[i] = r;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        bits[i] = '0;
        nb[i] = 0;
        ps[i] = 1'b0;
        pr[i] = 1'b0;
      end
    end else begin
      chk("main_outputs", {28'd0, bus_m.busy, bus_m.sclk, bus_m.sdout, bus_m.rclk},
          {28'd0, model_out(12, 4, act_m, k_m, word_m, cyc)});
      chk("main_drop", {31'd0, bus_m.drop}, 32'(drop_exp.exists(cyc)));
      chk("w1_outputs", {28'd0, bus_1.busy, bus_1.sclk, bus_1.sdout, bus_1.rclk},
          {28'd0, model_out(1, 1, act_1, k_1, word_1, cyc)});
      chk("w32_outputs", {28'd0, bus_32.busy, bus_32.sclk, bus_32.sdout, bus_32.rclk},
          {28'd0, model_out(32, 256, act_32, k_32, word_32, cyc)});
      chk("edge_drop", {30'd0, bus_1.drop, bus_32.drop}, 32'd0);
      frame_mon(0, bus_m.sclk, bus_m.sdout, bus_m.rclk, 12);
      frame_mon(1, bus_1.sclk, bus_1.sdout, bus_1.rclk, 1);
      frame_mon(2, bus_32.sclk, bus_32.sdout, bus_32.rclk, 32);
    end
  end

  // one negedge-to-negedge cycle of the main instance's write port
  task automatic drive_m(input bit w, input logic [31:0] d);
    bus_m.wr = w;
    bus_m.wdata = d[11:0];
    if (w) begin
      if (cyc + 1 >= free_m) begin
        k_m = cyc + 1;
        word_m = d & 32'hFFF;
        act_m = 1;
        free_m = k_m + 25 * 4 + 1;
        exp_q.push_back(d & 32'hFFF);
      end else begin
        drop_exp[cyc + 1] = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_free_m();
    while (cyc + 1 < free_m) drive_m(1'b0, $urandom);
  endtask

  task automatic main_seq();
    drive_m(1'b1, 32'hA5C);
    wait_free_m();
    drive_m(1'b1, $urandom);
    drive_m(1'b1, $urandom);
    drive_m(1'b1, $urandom);
    while (cyc + 2 < free_m) drive_m(1'b0, $urandom);
    drive_m(1'b1, 32'h123);
    repeat (4) drive_m(1'b0, $urandom);
    drive_m(1'b1, 32'hFFF);
    wait_free_m();
    drive_m(1'b1, 32'h001);
    wait_free_m();
    repeat (8) begin
      drive_m(1'b1, $urandom);
      repeat ($urandom_range(0, 120)) drive_m($urandom_range(0, 7) == 0, $urandom);
    end
    wait_free_m();
    repeat (3) drive_m(1'b0, $urandom);
  endtask

  task automatic edge_seq();
    bus_1.wr = 1'b1;
    bus_1.wdata = 1'b1;
    k_1 = cyc + 1;
    word_1 = 32'h1;
    act_1 = 1;
    exp_q1.push_back(32'h1);
    @(negedge clk);
    bus_1.wr = 1'b0;
    repeat (6) @(negedge clk);
    bus_32.wr = 1'b1;
    bus_32.wdata = 32'h8000_0001;
    k_32 = cyc + 1;
    word_32 = 32'h8000_0001;
    act_32 = 1;
    exp_q32.push_back(32'h8000_0001);
    @(negedge clk);
    bus_32.wr = 1'b0;
    repeat (65 * 256 + 5) begin
      bus_32.wdata = $urandom;
      @(negedge clk);
    end
  endtask

  initial begin
    bus_m.wr = 1'b0;  bus_m.wdata = '0;
    bus_1.wr = 1'b0;  bus_1.wdata = '0;
    bus_32.wr = 1'b0; bus_32.wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, bus_m.busy, bus_m.drop, bus_m.sclk, bus_m.sdout, bus_m.rclk}, 32'd0);
    chk("reset_state", 32'(bus_m.state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    fork
      main_seq();
      edge_seq();
    join

    // abort a frame mid-shift: everything drops at once and no latch pulse follows
    drive_m(1'b1, 32'hB3A);
    repeat (30) drive_m(1'b0, $urandom);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {27'd0, bus_m.busy, bus_m.drop, bus_m.sclk, bus_m.sdout, bus_m.rclk}, 32'd0);
    chk("async_reset_state", 32'(bus_m.state), 32'd0);
    act_m = 0;
    free_m = 0;
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", 32'(bus_m.state), 32'd0);
    drive_m(1'b1, 32'h5A5);
    wait_free_m();
    repeat (3) drive_m(1'b0, $urandom);

    chk("queue_empty_main", 32'(exp_q.size()), 32'd0);
    chk("queue_empty_w1", 32'(exp_q1.size()), 32'd0);
    chk("queue_empty_w32", 32'(exp_q32.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
